// File: rtl/theta_phase_gen.sv
// Per-step angle generator: advances a Q0.32 turn accumulator, scales it by 2*pi
// and emits theta as an IEEE-754 single, pulsing done_sig to start the sine stage.
module theta_phase_gen #(
  parameter logic [31:0] TWO_PI_Q   = 32'hC90FDAA2,
  parameter logic [31:0] INIT_PHASE = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sta,
  input  logic [31:0] freq_word,
  input  logic        load,
  input  logic [31:0] load_phase,
  output logic [31:0] theta,
  output logic        done_sig,
  output logic        wrap,
  output logic        busy,
  output logic        overrun
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ACC  = 3'd1;
  localparam logic [2:0] MUL  = 3'd2;
  localparam logic [2:0] NORM = 3'd3;
  localparam logic [2:0] PACK = 3'd4;

  logic [2:0]  state_q;
  logic [31:0] phase_q;
  logic        wrap_pend_q;
  logic [31:0] prod_hi_q;
  logic [31:0] t32_q;
  logic [4:0]  p_q;
  logic        zero_q;
  logic [31:0] packed_q;
  logic [31:0] theta_q;
  logic        done_q;
  logic        wrap_q;
  logic        busy_q;
  logic        overrun_q;

  logic [31:0] base_d;
  logic [32:0] sum_d;
  logic [63:0] prod_d;
  logic [4:0]  lead_p_d;
  logic        lead_zero_d;
  logic [7:0]  exp_d;
  logic [22:0] mant_d;
  logic [31:0] packed_d;

  // A load in the accepting cycle replaces the accumulator before the increment.
  assign base_d = load ? load_phase : phase_q;
  assign sum_d  = {1'b0, base_d} + {1'b0, freq_word};

  // Only the upper half of the product carries the Q3.29 angle; the low half is dropped.
  assign prod_d = 64'(phase_q) * 64'(TWO_PI_Q);

  always_comb begin
    lead_p_d    = 5'd0;
    lead_zero_d = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (prod_hi_q[i]) begin
        lead_p_d    = 5'(i);
        lead_zero_d = 1'b0;
      end
    end
  end

  // Left-justify so the leading one sits at bit 31; the 23 bits below it are the mantissa.
  assign exp_d    = 8'd98 + {3'b000, p_q};
  assign mant_d   = 23'((t32_q << (5'd31 - p_q)) >> 8);
  assign packed_d = zero_q ? 32'h00000000 : {1'b0, exp_d, mant_d};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      phase_q     <= INIT_PHASE;
      wrap_pend_q <= 1'b0;
      prod_hi_q   <= 32'h0;
      t32_q       <= 32'h0;
      p_q         <= 5'd0;
      zero_q      <= 1'b0;
      packed_q    <= 32'h0;
      theta_q     <= 32'h0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (sta && (state_q != IDLE)) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (load) overrun_q <= 1'b0;
          if (sta) begin
            phase_q     <= sum_d[31:0];
            wrap_pend_q <= sum_d[32];
            busy_q      <= 1'b1;
            state_q     <= ACC;
          end else if (load) begin
            phase_q <= load_phase;
          end
        end
        ACC: begin
          prod_hi_q <= prod_d[63:32];
          state_q   <= MUL;
        end
        MUL: begin
          t32_q   <= prod_hi_q;
          p_q     <= lead_p_d;
          zero_q  <= lead_zero_d;
          state_q <= NORM;
        end
        NORM: begin
          packed_q <= packed_d;
          state_q  <= PACK;
        end
        PACK: begin
          theta_q <= packed_q;
          done_q  <= 1'b1;
          wrap_q  <= wrap_pend_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign theta    = theta_q;
  assign done_sig = done_q;
  assign wrap     = wrap_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_theta_phase_gen.sv
// Bench for theta_phase_gen: table-driven steps feeding an expected-result queue
// that a negedge monitor pops on every done_sig, plus overrun and mid-run reset sequences.
module tb_theta_phase_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sta = 1'b0;
  logic [31:0] freq_word = 32'h0;
  logic        load = 1'b0;
  logic [31:0] load_phase = 32'h0;
  logic [31:0] theta;
  logic        done_sig;
  logic        wrap;
  logic        busy;
  logic        overrun;

  int nChecks = 0;
  int nFails = 0;
  int busyTotal = 0;

  typedef struct {
    logic        doLoad;
    logic [31:0] ldPhase;
    logic        doSta;
    logic [31:0] fw;
    logic [31:0] expTheta;
    logic        expWrap;
  } vec_t;

  typedef struct {
    logic [31:0] theta;
    logic        wrap;
  } exp_t;

  exp_t expQ[$];
  vec_t vecs[11];

  theta_phase_gen dut (
    .clk(clk), .rst(rst), .sta(sta), .freq_word(freq_word), .load(load),
    .load_phase(load_phase), .theta(theta), .done_sig(done_sig), .wrap(wrap),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: angle = phase * 2pi in Q3.29, converted by scanning for the top set bit.
  function automatic logic [31:0] modelTheta(input logic [31:0] phase);
    logic [63:0] prod;
    logic [31:0] t;
    logic [31:0] m;
    int p;
    prod = 64'(phase) * 64'hC90FDAA2;
    t = prod[63:32];
    if (t == 32'h0) return 32'h0;
    p = 31;
    while (t[p] == 1'b0) p--;
    m = t << (31 - p);
    return {1'b0, 8'(98 + p), m[30:8]};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (busy) busyTotal++;
      if (done_sig) begin
        if (expQ.size() == 0) begin
          check("spuriousDone", 32'(done_sig), 32'h0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          check("theta", theta, e.theta);
          check("wrap", 32'(wrap), 32'(e.wrap));
        end
      end else if (wrap) begin
        check("wrapWithoutDone", 32'(wrap), 32'h0);
      end
    end
  end

  task automatic waitDone();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 12) begin
      @(posedge clk);
      n++;
    end
    check("doneSeen", 32'(expQ.size()), 32'h0);
    expQ.delete();
  endtask

  task automatic applyStimulus(input logic doLoad, input logic [31:0] ldPhase, input logic doSta,
                               input logic [31:0] fw, input logic [31:0] expTheta, input logic expWrap);
    int busyStart;
    @(posedge clk); #1;
    busyStart = busyTotal;
    load = doLoad; load_phase = ldPhase; sta = doSta; freq_word = fw;
    if (doSta) expQ.push_back('{expTheta, expWrap});
    @(posedge clk); #1;
    load = 1'b0; sta = 1'b0;
    if (doSta) begin
      waitDone();
      check("busyCycles", 32'(busyTotal - busyStart), 32'd4);
    end else begin
      repeat (6) @(posedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'h0,        1'b1, 32'h40000000, 32'h3FC90FDA, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,        1'b1, 32'h40000000, 32'h40490FDA, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,        1'b1, 32'h40000000, 32'h4096CBE3, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,        1'b1, 32'h40000000, 32'h00000000, 1'b1};
    vecs[4]  = '{1'b1, 32'h80000000, 1'b0, 32'h0,        32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h0,        1'b1, 32'h00000000, 32'h40490FDA, 1'b0};
    vecs[6]  = '{1'b1, 32'h00000000, 1'b0, 32'h0,        32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h0,        1'b1, 32'h00000001, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[9]  = '{1'b1, 32'h40000000, 1'b1, 32'h40000000, 32'h40490FDA, 1'b0};
    vecs[10] = '{1'b1, 32'hC0000000, 1'b1, 32'h40000000, 32'h00000000, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("rstTheta", theta, 32'h0);
    check("rstDone", 32'(done_sig), 32'h0);
    check("rstWrap", 32'(wrap), 32'h0);
    check("rstBusy", 32'(busy), 32'h0);
    check("rstOverrun", 32'(overrun), 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++)
      applyStimulus(vecs[i].doLoad, vecs[i].ldPhase, vecs[i].doSta, vecs[i].fw,
                    vecs[i].expTheta, vecs[i].expWrap);
    check("overrunIdle", 32'(overrun), 32'h0);

    // Second strobe two cycles after acceptance must be dropped and flagged.
    @(posedge clk); #1;
    sta = 1'b1; freq_word = 32'h40000000;
    expQ.push_back('{32'h3FC90FDA, 1'b0});
    @(posedge clk); #1;
    sta = 1'b0;
    @(posedge clk); #1;
    sta = 1'b1; freq_word = 32'h12345678;
    @(posedge clk); #1;
    sta = 1'b0;
    check("overrunSet", 32'(overrun), 32'h1);
    waitDone();
    repeat (3) @(posedge clk);
    check("overrunSticky", 32'(overrun), 32'h1);
    applyStimulus(1'b1, 32'h40000000, 1'b1, 32'h0, 32'h3FC90FDA, 1'b0);
    check("overrunCleared", 32'(overrun), 32'h0);

    // Reset while the conversion sits in MUL aborts it with no late done_sig.
    @(posedge clk); #1;
    sta = 1'b1; freq_word = 32'h40000000;
    @(posedge clk); #1;
    sta = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midRstTheta", theta, 32'h0);
    check("midRstBusy", 32'(busy), 32'h0);
    check("midRstDone", 32'(done_sig), 32'h0);
    check("midRstWrap", 32'(wrap), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (8) @(posedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h40000000, 32'h3FC90FDA, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ph;
      logic [31:0] fw;
      logic [32:0] s;
      ph = $urandom;
      fw = $urandom;
      s = {1'b0, ph} + {1'b0, fw};
      applyStimulus(1'b1, ph, 1'b1, fw, modelTheta(s[31:0]), s[32]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
